rgb_to_yuv_sequencer: RTL and testbench
=======================================

Name: rgb_to_yuv_sequencer

Overview:
Time-multiplexed RGB888 to YUV (PAL) converter controller. It shares one 24x8 multiplier and one 32-bit accumulator across all nine coefficient products, sequenced by a step counter. Results are bit-exact to the full-parallel combinational conversion. It sits between the pixel fetch stage and the PAL chroma modulator, where pixel rate is at most 1/9 of clk and area matters more than throughput.

Parameters:
COEF_W, 24, coefficient magnitude width; fixed, listed for documentation only.
ACC_W, 32, accumulator width; arithmetic is modulo 2^32; fixed.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; drops any in-flight pixel
in_valid  in  1  r/g/b valid
in_ready  out  1  sequencer can accept a pixel this cycle
r  in  8  red, unsigned
g  in  8  green, unsigned
b  in  8  blue, unsigned
out_valid  out  1  y/u/v valid
out_ready  in  1  downstream accepts y/u/v
y  out  8  luma, unsigned
u  out  9  U chroma, two's complement
v  out  9  V chroma, two's complement

Behaviour:
- Reset (reset_n low, async): state=IDLE, step=0, acc=0, y=0, u=0, v=0, out_valid=0, latched rgb=0.
- States and transitions:
  - IDLE: accept -> CALC.
  - CALC: steps 0..8, one per clk. After step 8 -> DONE.
  - DONE: out_valid=1. On out_ready & accept -> CALC. On out_ready without accept -> IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The combinational path from out_ready to in_ready is intentional.
- Accept = in_valid & in_ready. r/g/b are latched on accept and held stable through CALC, so input may change afterwards.
- Step schedule (component, channel, sign, coefficient):
  - 0: Y, R, +, 5016388
  - 1: Y, G, +, 9848226
  - 2: Y, B, +, 1912603
  - 3: U, R, -, 1233125
  - 4: U, G, -, 2424308
  - 5: U, B, +, 3657433
  - 6: V, R, +, 5158994
  - 7: V, G, -, 4320133
  - 8: V, B, -, 838861
- Accumulation: at steps 0/3/6, acc_next = round_const ± coef*chan. Otherwise acc_next = acc ± coef*chan. Product is zero-extended to 32 bits; add/subtract is modulo 2^32.
- Rounding constants: Y 32'h0080_0000; U and V 32'h0040_0000.
- Result capture on the cycle acc_next completes a component:
  - step 2: y <= acc_next[31:24]
  - step 5: u <= acc_next[31:23]
  - step 8: v <= acc_next[31:23]
- Latency: out_valid rises on the 9th rising edge after the accept edge. Back-to-back throughput is 1 pixel / 9 clk when out_ready is held high in DONE.
- y/u/v hold stable while out_valid & !out_ready. Registers may update during CALC, but out_valid is 0 then.
- flush (priority over accept and out_ready): next state IDLE, step=0, out_valid=0. y/u/v keep their last values. An in_valid in the flush cycle is not accepted; in_ready is forced 0 that cycle.
- reset_n asserted mid-CALC or in DONE: immediate return to reset values; the pixel is lost, no partial output.
- No overflow detection. Wrap is defined by modulo arithmetic and matches the reference formula for all 2^24 inputs.

Decomposition:
- Package rgb_yuv_pkg holds:
  - the nine coefficient localparams and their sign bits (as a 9-entry constant array indexed by step);
  - Y_ROUND and UV_ROUND;
  - the state enum {IDLE, CALC, DONE};
  - STEP_LAST = 4'd8.
- Sub-module yuv_mac: combinational 24x8 unsigned multiply plus 32-bit add/sub with a "load round_const" select. The controller owns step counter, FSM, latches and output registers.

Test Plan:
- White (255,255,255), out_ready=1 -> y=255, u=0, v=0; out_valid exactly 9 clk after accept.
- Red (255,0,0) -> y=76, u=9'h1DB (-37), v=157. Blue (0,0,255) -> y=29, u=111, v=9'h1E6 (-26). Black -> 0,0,0.
- Backpressure: out_ready=0 for 20 clk after DONE -> in_ready=0 and y/u/v stable. Release with in_valid=1 -> same-cycle accept; next result 9 clk later.
- Stream 100 random pixels with random in_valid/out_ready -> every output bit-exact to the parallel formula model; in-order; none dropped or duplicated.
- flush at step 4, then a new pixel -> no out_valid for the aborted pixel; new pixel result correct.
- reset_n low at step 6, async mid-cycle -> outputs 0 immediately; after release in_ready=1 and the next pixel converts correctly.

Source files
------------

// File: rtl/rgb_yuv_pkg.sv
// Shared constants and types for the time-multiplexed RGB888 -> YUV (PAL) sequencer.
package rgb_yuv_pkg;

  localparam int COEF_W = 24;
  localparam int ACC_W  = 32;

  localparam logic [3:0] STEP_LAST = 4'd8;

  // Rounding offsets: half an LSB of the Y (>>24) and U/V (>>23) result slices.
  localparam logic [ACC_W-1:0] Y_ROUND  = 32'h0080_0000;
  localparam logic [ACC_W-1:0] UV_ROUND = 32'h0040_0000;

  // Coefficient magnitudes indexed by step: Y(R,G,B), U(R,G,B), V(R,G,B).
  localparam logic [COEF_W-1:0] COEF_TABLE [9] = '{
    24'd5016388, 24'd9848226, 24'd1912603,
    24'd1233125, 24'd2424308, 24'd3657433,
    24'd5158994, 24'd4320133, 24'd838861
  };

  // 1 = subtract the product, 0 = add it.
  localparam logic COEF_SUB [9] = '{
    1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b0,
    1'b0, 1'b1, 1'b1
  };

  typedef enum logic [1:0] {IDLE, CALC, DONE} seqState;

  // Coefficient lookup that stays defined for the unused step codes 9..15.
  function automatic logic [COEF_W-1:0] coefForStep(input logic [3:0] step);
    if (step <= STEP_LAST) return COEF_TABLE[step];
    return '0;
  endfunction

  function automatic logic subForStep(input logic [3:0] step);
    if (step <= STEP_LAST) return COEF_SUB[step];
    return 1'b0;
  endfunction

endpackage

// File: rtl/yuv_mac.sv
// Shared multiply-accumulate: one 24x8 unsigned product added to or subtracted
// from either the running accumulator or a rounding constant, modulo 2^32.
module yuv_mac
  import rgb_yuv_pkg::*;
(
  input  logic [COEF_W-1:0] coef,
  input  logic [7:0]        chan,
  input  logic              subtract,
  input  logic              loadRound,
  input  logic [ACC_W-1:0]  roundConst,
  input  logic [ACC_W-1:0]  accIn,
  output logic [ACC_W-1:0]  accOut
);

  logic [ACC_W-1:0] product;
  logic [ACC_W-1:0] base;

  // 24x8 product fits exactly in 32 bits; the base selects a fresh component or the running sum.
  always_comb begin
    product = ACC_W'(coef) * ACC_W'(chan);
    base    = loadRound ? roundConst : accIn;
    accOut  = subtract ? (base - product) : (base + product);
  end

endmodule

// File: rtl/rgb_to_yuv_sequencer.sv
// RGB888 -> YUV (PAL) converter that walks nine coefficient products through a
// single MAC, one per clock, producing one pixel every nine cycles.
module rgb_to_yuv_sequencer
  import rgb_yuv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y,
  output logic [8:0] u,
  output logic [8:0] v
);

  seqState          stateReg;
  seqState          stateNext;
  logic [3:0]       stepReg;
  logic [ACC_W-1:0] accReg;
  logic [ACC_W-1:0] accNext;
  logic [7:0]       rLatch;
  logic [7:0]       gLatch;
  logic [7:0]       bLatch;
  logic [7:0]       yReg;
  logic [8:0]       uReg;
  logic [8:0]       vReg;

  logic             accept;
  logic             calcActive;
  logic [7:0]       chanValue;
  logic             loadRound;
  logic [ACC_W-1:0] roundConst;

  assign accept     = in_valid & in_ready;
  assign calcActive = (stateReg == CALC) & ~flush;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stateReg <= IDLE;
    else          stateReg <= stateNext;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    stateNext = stateReg;
    if (flush) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE: if (accept) stateNext = CALC;
        CALC: if (stepReg == STEP_LAST) stateNext = DONE;
        DONE: if (out_ready) stateNext = accept ? CALC : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Handshake outputs; out_ready feeds in_ready combinationally so DONE can chain into CALC.
  always_comb begin
    out_valid = (stateReg == DONE);
    in_ready  = ~flush & ((stateReg == IDLE) | ((stateReg == DONE) & out_ready));
  end

  // Per-step operand selection: channel cycles R,G,B and each component restarts from its rounding offset.
  always_comb begin
    case (stepReg)
      4'd0, 4'd3, 4'd6: chanValue = rLatch;
      4'd1, 4'd4, 4'd7: chanValue = gLatch;
      default:          chanValue = bLatch;
    endcase
    loadRound  = (stepReg == 4'd0) | (stepReg == 4'd3) | (stepReg == 4'd6);
    roundConst = (stepReg < 4'd3) ? Y_ROUND : UV_ROUND;
  end

  yuv_mac uMac (
    .coef       (coefForStep(stepReg)),
    .chan       (chanValue),
    .subtract   (subForStep(stepReg)),
    .loadRound  (loadRound),
    .roundConst (roundConst),
    .accIn      (accReg),
    .accOut     (accNext)
  );

  // Pixel latch, step counter, accumulator and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rLatch  <= '0;
      gLatch  <= '0;
      bLatch  <= '0;
      stepReg <= '0;
      accReg  <= '0;
      yReg    <= '0;
      uReg    <= '0;
      vReg    <= '0;
    end else begin
      if (accept) begin
        rLatch <= r;
        gLatch <= g;
        bLatch <= b;
      end
      if (calcActive) begin
        accReg  <= accNext;
        stepReg <= (stepReg == STEP_LAST) ? 4'd0 : stepReg + 4'd1;
        case (stepReg)
          4'd2:    yReg <= accNext[31:24];
          4'd5:    uReg <= accNext[31:23];
          4'd8:    vReg <= accNext[31:23];
          default: ;
        endcase
      end else begin
        stepReg <= '0;
      end
    end
  end

  assign y = yReg;
  assign u = uReg;
  assign v = vReg;

endmodule

// File: tb/tb_rgb_to_yuv_sequencer.sv
// Self-checking bench: directed literal pixels, backpressure, flush, async reset
// and a randomized stream compared against a parallel-formula model.
module tb_rgb_to_yuv_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] r = '0;
  logic [7:0] g = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic [8:0] u;
  logic [8:0] v;

  always #5 clk = ~clk;

  rgb_to_yuv_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r         (r),
    .g         (g),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .u         (u),
    .v         (v)
  );

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;
  int nAccepted = 0;
  int nEmitted = 0;
  int nDropped = 0;

  typedef struct {
    logic [25:0] yuv;
    int          edgeNo;
  } expT;

  expT         q[$];
  expT         e;
  logic        prevStall = 1'b0;
  logic        prevValid = 1'b0;
  logic [25:0] prevYuv = '0;

  localparam logic [25:0] WHITE = {8'd255, 9'd0, 9'd0};
  localparam logic [25:0] RED   = {8'd76, 9'h1DB, 9'd157};
  localparam logic [25:0] BLUE  = {8'd29, 9'd111, 9'h1E6};
  localparam logic [25:0] BLACK = 26'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Parallel reference: each component as one signed sum, truncated to 32 bits then sliced.
  function automatic logic [25:0] refYuv(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    longint      sy, su, sv;
    logic [31:0] ty, tu, tv;
    sy = 64'sd8388608 + 64'sd5016388 * longint'(rr) + 64'sd9848226 * longint'(gg) + 64'sd1912603 * longint'(bb);
    su = 64'sd4194304 - 64'sd1233125 * longint'(rr) - 64'sd2424308 * longint'(gg) + 64'sd3657433 * longint'(bb);
    sv = 64'sd4194304 + 64'sd5158994 * longint'(rr) - 64'sd4320133 * longint'(gg) - 64'sd838861 * longint'(bb);
    ty = sy[31:0];
    tu = su[31:0];
    tv = sv[31:0];
    return {ty[31:24], tu[31:23], tv[31:23]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: handshake legality, stall stability, latency and scoreboard order.
  always @(negedge clk) begin
    if (!reset_n) begin
      nDropped += q.size();
      q.delete();
      prevStall = 1'b0;
      prevValid = 1'b0;
    end else begin
      if (q.size() == 0) begin
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'(!flush));
      end else if (out_valid) begin
        chk("done_in_ready", 32'(in_ready), 32'(out_ready && !flush));
      end else begin
        chk("busy_in_ready", 32'(in_ready), 32'd0);
      end
      if (prevStall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({y, u, v}), 32'(prevYuv));
      end
      if (out_valid && !prevValid && q.size() > 0)
        chk("latency", 32'(cyc - q[0].edgeNo), 32'd9);
      if (flush) begin
        nDropped += q.size();
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("stream_yuv", 32'({y, u, v}), 32'(e.yuv));
          nEmitted++;
        end
        if (in_valid && in_ready) begin
          e.yuv = refYuv(r, g, b);
          e.edgeNo = cyc + 1;
          q.push_back(e);
          nAccepted++;
        end
      end
      prevStall = out_valid && !out_ready && !flush;
      prevValid = out_valid;
      prevYuv = {y, u, v};
    end
  end

  task automatic waitValid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd9);
  endtask

  task automatic runPixel(input string name, input logic [7:0] pr, input logic [7:0] pg,
                          input logic [7:0] pb, input logic [25:0] expYuv);
    in_valid = 1'b1;
    out_ready = 1'b1;
    r = pr;
    g = pg;
    b = pb;
    tick();
    in_valid = 1'b0;
    r = 8'($urandom);
    g = 8'($urandom);
    b = 8'($urandom);
    waitValid(name);
    chk({name, "_yuv"}, 32'({y, u, v}), 32'(expYuv));
    tick();
  endtask

  initial begin
    int n;
    int guard;
    int base;

    // Pin the model to hand-computed values.
    chk("model_white", 32'(refYuv(8'd255, 8'd255, 8'd255)), 32'(WHITE));
    chk("model_red", 32'(refYuv(8'd255, 8'd0, 8'd0)), 32'(RED));
    chk("model_blue", 32'(refYuv(8'd0, 8'd0, 8'd255)), 32'(BLUE));

    #1 reset_n = 1'b0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_yuv", 32'({y, u, v}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1 chk("reset_in_ready", 32'(in_ready), 32'd1);

    runPixel("white", 8'd255, 8'd255, 8'd255, WHITE);
    runPixel("red", 8'd255, 8'd0, 8'd0, RED);
    runPixel("blue", 8'd0, 8'd0, 8'd255, BLUE);
    runPixel("black", 8'd0, 8'd0, 8'd0, BLACK);

    // Backpressure: hold DONE for 20 cycles with a pending pixel on the input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    r = 8'd255; g = 8'd0; b = 8'd0;
    tick();
    in_valid = 1'b0;
    waitValid("bp_red");
    in_valid = 1'b1;
    r = 8'd0; g = 8'd0; b = 8'd255;
    for (int i = 0; i < 20; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("bp_hold", 32'({y, u, v}), 32'(RED));
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    waitValid("bp_blue");
    chk("bp_blue_yuv", 32'({y, u, v}), 32'(BLUE));
    tick();

    // Flush at step 4, with in_valid asserted in the flush cycle.
    in_valid = 1'b1;
    r = 8'd17; g = 8'd200; b = 8'd90;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    in_valid = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      tick();
    end
    chk("flush_no_output", 32'(n), 32'd0);
    runPixel("after_flush", 8'd255, 8'd255, 8'd255, WHITE);

    // Async reset mid-CALC at step 6, once Y and U already hold partial results.
    in_valid = 1'b1;
    r = 8'd255; g = 8'd0; b = 8'd0;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("pre_reset_y", 32'(y), 32'd76);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_yuv", 32'({y, u, v}), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    #1 chk("after_reset_in_ready", 32'(in_ready), 32'd1);
    runPixel("after_reset", 8'd0, 8'd0, 8'd255, BLUE);

    // Randomized stream with random valid/ready.
    base = nAccepted;
    guard = 0;
    while ((nAccepted - base) < 100 && guard < 5000) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      tick();
      guard++;
    end
    chk("stream_budget", 32'(guard < 5000), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("in_out_balance", 32'(nEmitted + nDropped), 32'(nAccepted));
    chk("dropped_count", 32'(nDropped), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
